exp_subtractor_serial: RTL and testbench

- Bit-serial, multi-cycle 8-bit subtractor. It is the inverse operation of the FPU's ripple-carry exponent adder.
- Computes a − b LSB-first, one full-subtractor step per clock, with a registered borrow chain.
- Produces the modular difference, the final borrow (a < b) and |a − b|.
- Used in the FPU add/sub path to compare biased exponents and derive the mantissa alignment shift amount. Start/busy/done handshake.

---
 rtl/exp_subtractor_serial.sv | 93 +++++++++
 tb/tb_exp_subtractor_serial.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/exp_subtractor_serial.sv
// rtl/exp_subtractor_serial.sv - bit-serial LSB-first subtractor producing a-b, borrow and |a-b|
module exp_subtractor_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             a_lt_b,
    output logic [WIDTH-1:0] abs_diff
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SUB, ABS} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             borrow_r;
    logic [CW-1:0]    cnt;

    logic ai;
    logic bi;
    logic di;
    logic borrow_next;

    // One full-subtractor stage; the borrow is carried between clocks in borrow_r.
    assign ai          = a_sr[0];
    assign bi          = b_sr[0];
    assign di          = ai ^ bi ^ borrow_r;
    assign borrow_next = (~ai & bi) | (~(ai ^ bi) & borrow_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            borrow_r <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            diff     <= '0;
            a_lt_b   <= 1'b0;
            abs_diff <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        res_sr   <= '0;
                        borrow_r <= 1'b0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= SUB;
                    end
                end
                SUB: begin
                    done     <= 1'b0;
                    res_sr   <= {di, res_sr[WIDTH-1:1]};
                    a_sr     <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr     <= {1'b0, b_sr[WIDTH-1:1]};
                    borrow_r <= borrow_next;
                    cnt      <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= ABS;
                    end
                end
                ABS: begin
                    // Two's-complement negate of the wrapped result gives the magnitude.
                    diff     <= res_sr;
                    a_lt_b   <= borrow_r;
                    abs_diff <= borrow_r ? (~res_sr + 1'b1) : res_sr;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_exp_subtractor_serial.sv
// tb/tb_exp_subtractor_serial.sv - scoreboard bench for exp_subtractor_serial
module tb_exp_subtractor_serial;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       a_lt_b;
    logic [7:0] abs_diff;

    exp_subtractor_serial #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .a_lt_b   (a_lt_b),
        .abs_diff (abs_diff)
    );

    typedef struct {
        logic [7:0] d;
        logic       lt;
        logic [7:0] ab;
        int         dcyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   free_at = 0;
    logic [7:0] held_d = 0;
    logic       held_lt = 0;
    logic [7:0] held_ab = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on each accepted request; one op per 10 clocks.
    always @(posedge clk) begin
        exp_t e;
        int   ia;
        int   ib;
        cyc++;
        if (!rst_n) begin
            q.delete();
            free_at = 0;
        end else if (start && cyc >= free_at) begin
            ia     = int'(a);
            ib     = int'(b);
            e.lt   = (ia < ib);
            e.d    = 8'((ia - ib + 256) % 256);
            e.ab   = 8'(ia < ib ? ib - ia : ia - ib);
            e.dcyc = cyc + 9;
            q.push_back(e);
            free_at = cyc + 10;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held_d  = 0;
            held_lt = 0;
            held_ab = 0;
            chk("rst_done", 32'(done), 0);
            chk("rst_busy", 32'(busy), 0);
        end else begin
            chk("busy", 32'(busy), 32'(cyc <= free_at - 2));
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("done_latency", 32'(cyc), 32'(e.dcyc));
                    held_d  = e.d;
                    held_lt = e.lt;
                    held_ab = e.ab;
                end
            end else if (q.size() > 0 && q[0].dcyc <= cyc) begin
                e = q.pop_front();
                chk("missing_done", 0, 1);
            end
        end
        chk("diff", 32'(diff), 32'(held_d));
        chk("a_lt_b", 32'(a_lt_b), 32'(held_lt));
        chk("abs_diff", 32'(abs_diff), 32'(held_ab));
    end

    task automatic op(input logic [7:0] va, input logic [7:0] vb);
        @(negedge clk);
        start = 1'b1;
        a     = va;
        b     = vb;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = 0;
        b     = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        op(8'd130, 8'd127);
        op(8'd127, 8'd130);
        op(8'd0,   8'd255);
        op(8'd200, 8'd200);
        op(8'd255, 8'd0);

        // Second request while busy must be ignored.
        @(negedge clk);
        start = 1'b1; a = 8'd10; b = 8'd5;
        @(negedge clk);
        start = 1'b0; a = 8'd99; b = 8'd98;
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'd1; b = 8'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);

        // Asynchronous reset in the middle of SUB.
        @(negedge clk);
        start = 1'b1; a = 8'd10; b = 8'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_done", 32'(done), 0);
        chk("async_rst_diff", 32'(diff), 0);
        chk("async_rst_lt", 32'(a_lt_b), 0);
        chk("async_rst_abs", 32'(abs_diff), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        op(8'd7, 8'd9);

        // Back-to-back: start kept high into the done cycle with new operands.
        @(negedge clk);
        start = 1'b1; a = 8'd5; b = 8'd3;
        repeat (10) @(negedge clk);
        a = 8'd64; b = 8'd96;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);

        // Random traffic, mostly continuous start, biased toward boundary operands.
        for (int i = 0; i < 11000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 7))
                0: begin a = 8'($urandom); b = a; end
                1: begin a = 8'd0; b = 8'hFF; end
                2: begin a = 8'hFF; b = 8'($urandom); end
                default: begin a = 8'($urandom); b = 8'($urandom); end
            endcase
        end
        start = 1'b0;
        repeat (15) @(negedge clk);
        chk("drain", 32'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
